mem_responder: RTL
==================

# mem_responder

Data-memory responder for the multicycle RISC-V core: the slave end of the control FSM's load/store requests. Accepts one request at a time over a req/ready handshake, performs the byte/half/word access with a fixed latency against an internal word array, and returns sign- or zero-extended load data with a single-cycle ack. It sits between the control FSM and datapath on one side and the data storage on the other.

## Interface
Parameters:
- DEPTH_WORDS, 256, number of 32-bit words in the array; power of two, ≥ 4.
- LATENCY, 2, cycles from the accept edge to the ack cycle; integer ≥ 1.

Ports:
- CLK  in  1  clock, rising edge.
- RST  in  1  reset, asynchronous, active-high.
- req  in  1  request valid; initiator holds req and all request fields until it is accepted.
- we  in  1  1 = store, 0 = load.
- funct3  in  3  RISC-V size code: 000 B, 001 H, 010 W, 100 BU, 101 HU (BU/HU are load-only).
- addr  in  32  byte address.
- wdata  in  32  store data; the low bits are used for B/H.
- ready  out  1  responder idle; a request is accepted on a rising edge where req && ready.
- ack  out  1  one-cycle pulse marking completion.
- rdata  out  32  load result; valid in the ack cycle and held until the next ack.
- err  out  1  valid with ack: access rejected.

## Operation
- FSM states: IDLE, BUSY, RESP.
  - IDLE: ready=1. On req, capture we, funct3, addr, wdata. Go to BUSY if LATENCY > 1, otherwise to RESP.
  - BUSY: ready=0. Down-counter loaded with LATENCY-1 at accept. Go to RESP on the edge where the count reaches 1.
  - RESP: ack=1, ready=0. Next state is always IDLE.
- req is ignored while ready=0; no queuing.
- Word index = addr[log2(DEPTH_WORDS)+1:2]. Upper address bits are discarded, so accesses wrap modulo the array size.
- Byte lanes are little-endian.
  - B uses lane addr[1:0].
  - H uses lanes {addr[1],0}+1 : {addr[1],0}.
- Load extension:
  - B and H sign-extend.
  - BU and HU zero-extend.
  - W passes through.
- Stores write only the selected byte lanes; the other lanes keep their value.
- Commit point is the edge entering RESP. On that edge:
  - the store is written;
  - the load word is read and registered into rdata.
- Illegal funct3 (011, 110, 111, or BU/HU with we=1):
  - no array access;
  - ack with err=1;
  - rdata=0.
- A store followed by a load to the same word returns the new data.
- Array contents are not reset.

## Timing
- Reset values: state IDLE, ready=1, ack=0, rdata=0, err=0, counter=0.
- Latency: accept at edge N, ack high during cycle N+LATENCY.
- Throughput: one transaction per LATENCY+1 cycles. ready rises the cycle after ack.
- RST mid-transaction:
  - immediate return to IDLE;
  - a store whose commit edge has not occurred is dropped;
  - no ack is produced.
- RST asserted in the same cycle as req: the request is not accepted.
- err only changes at the RESP entry edge, and is 0 whenever ack=0 after that cycle.

## Configuration
- MEM_MISALIGN_CHECK_EN
  - Defined: an H access with addr[0]=1, or a W access with addr[1:0]≠0, is rejected the same way as an illegal funct3 (err=1, no write, rdata=0).
  - Undefined: low address bits below the access size are forced to 0 (natural alignment), the access proceeds, and err is only raised for illegal funct3.

## Structure
- Package mem_pkg:
  - funct3 constants (F3_B, F3_H, F3_W, F3_BU, F3_HU);
  - state enum {IDLE, BUSY, RESP};
  - localparam for word-index width derived from DEPTH_WORDS.
- Sub-module load_store_align, purely combinational:
  - store path: funct3 + addr[1:0] + wdata → 4-bit byte enable, lane-shifted write data, illegal/misaligned flag;
  - load path: funct3 + addr[1:0] + read word → extended rdata.
- mem_responder owns the FSM, the counter, the capture registers and the array.

## Test plan
- Reset then SW 0xDEADBEEF to addr 0x10, LATENCY=2: accept at edge N, ack at cycle N+2, err=0. Then LW 0x10 → rdata 0xDEADBEEF.
- After the previous test, LB 0x13 → 0xFFFFFFDE; LBU 0x13 → 0x000000DE; LH 0x12 → 0xFFFFDEAD; LHU 0x10 → 0x0000BEEF.
- SB 0x11 with wdata 0x55 over 0xDEADBEEF, then LW 0x10 → 0xDEAD55EF.
- LW at addr 0x10 + 4·DEPTH_WORDS → same data as addr 0x10 (wrap).
- funct3=011 load, and funct3=100 with we=1 → ack with err=1, rdata=0, memory unchanged. LH 0x11 → err=1 with MEM_MISALIGN_CHECK_EN; without it, returns the halfword at 0x10.
- Accept SW 0x20, assert RST in the BUSY cycle → no ack, ready=1 after release. Then LW 0x20 → the old value. Also check that req held during BUSY is not accepted twice.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared definitions for the data-memory responder: RISC-V size codes,
// FSM state encoding and the word-index width helper.
package mem_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_t;

    function automatic int word_idx_width(input int depth_words);
        return $clog2(depth_words);
    endfunction

    localparam int DEFAULT_DEPTH_WORDS = 256;
    localparam int MEM_IDX_W           = word_idx_width(DEFAULT_DEPTH_WORDS);

endpackage

// File: rtl/load_store_align.sv
// Combinational byte-lane steering for loads and stores, plus access legality.
// MEM_MISALIGN_CHECK_EN turns misaligned H/W accesses into rejects instead of aligning them.
module load_store_align
    import mem_pkg::*;
(
    input  logic        we,
    input  logic [2:0]  funct3,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] wdata,
    input  logic [31:0] rword,
    output logic [3:0]  byte_en,
    output logic [31:0] wdata_lanes,
    output logic        bad,
    output logic [31:0] rdata_ext
);

    logic [1:0]  lo;
    logic        misaligned;
    logic        reject_misaligned;
    logic        illegal;
    logic [7:0]  byte_val;
    logic [15:0] half_val;

    // Natural alignment: drop the address bits below the access size.
    always_comb begin
        lo         = addr_lo;
        misaligned = 1'b0;
        case (funct3)
            F3_H, F3_HU: begin
                misaligned = addr_lo[0];
                lo[0]      = 1'b0;
            end
            F3_W: begin
                misaligned = |addr_lo;
                lo         = 2'b00;
            end
            default: ;
        endcase
    end

`ifdef MEM_MISALIGN_CHECK_EN
    assign reject_misaligned = misaligned;
`else
    logic unused_misaligned;
    assign unused_misaligned = misaligned;
    assign reject_misaligned = 1'b0;
`endif

    assign byte_val = rword[{lo, 3'b000} +: 8];
    assign half_val = lo[1] ? rword[31:16] : rword[15:0];

    always_comb begin
        illegal     = 1'b0;
        byte_en     = 4'b0000;
        wdata_lanes = 32'h0;
        rdata_ext   = 32'h0;
        case (funct3)
            F3_B: begin
                byte_en     = 4'b0001 << lo;
                wdata_lanes = {4{wdata[7:0]}};
                rdata_ext   = {{24{byte_val[7]}}, byte_val};
            end
            F3_BU: begin
                illegal   = we;
                byte_en   = 4'b0001 << lo;
                rdata_ext = {24'h0, byte_val};
            end
            F3_H: begin
                byte_en     = lo[1] ? 4'b1100 : 4'b0011;
                wdata_lanes = {2{wdata[15:0]}};
                rdata_ext   = {{16{half_val[15]}}, half_val};
            end
            F3_HU: begin
                illegal   = we;
                byte_en   = lo[1] ? 4'b1100 : 4'b0011;
                rdata_ext = {16'h0, half_val};
            end
            F3_W: begin
                byte_en     = 4'b1111;
                wdata_lanes = wdata;
                rdata_ext   = rword;
            end
            default: illegal = 1'b1;
        endcase
        bad = illegal | reject_misaligned;
        if (bad) begin
            byte_en   = 4'b0000;
            rdata_ext = 32'h0;
        end
    end

endmodule

// File: rtl/mem_responder.sv
// Fixed-latency load/store responder with a byte-lane word array.
// Optional MEM_MISALIGN_CHECK_EN rejects misaligned H/W accesses (see load_store_align).
module mem_responder
    import mem_pkg::*;
#(
    parameter int DEPTH_WORDS = 256,
    parameter int LATENCY     = 2
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        req,
    input  logic        we,
    input  logic [2:0]  funct3,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        ready,
    output logic        ack,
    output logic [31:0] rdata,
    output logic        err
);

    localparam int IDX_W = word_idx_width(DEPTH_WORDS);
    localparam int CNT_W = (LATENCY > 2) ? $clog2(LATENCY) : 1;

    state_t             state_reg;
    logic [CNT_W-1:0]   cnt_reg;
    logic               we_reg;
    logic [2:0]         funct3_reg;
    logic [IDX_W+1:0]   addr_reg;
    logic [31:0]        wdata_reg;
    logic               ready_reg;
    logic               ack_reg;
    logic               err_reg;
    logic [31:0]        rdata_reg;

    logic               in_idle;
    logic               cur_we;
    logic [2:0]         cur_funct3;
    logic [IDX_W+1:0]   cur_addr;
    logic [31:0]        cur_wdata;
    logic [IDX_W-1:0]   word_idx;
    logic [31:0]        rword;
    logic [3:0]         byte_en;
    logic [31:0]        wdata_lanes;
    logic               bad;
    logic [31:0]        rdata_ext;
    logic               commit;
    logic               mem_wr;
    logic [31:0]        rdata_next;

    logic unused_addr_bits;
    assign unused_addr_bits = &{1'b0, addr[31:IDX_W+2]};

    // With LATENCY=1 the commit happens on the accept edge, so the live inputs drive the access.
    assign in_idle    = (state_reg == IDLE);
    assign cur_we     = in_idle ? we                : we_reg;
    assign cur_funct3 = in_idle ? funct3            : funct3_reg;
    assign cur_addr   = in_idle ? addr[IDX_W+1:0]   : addr_reg;
    assign cur_wdata  = in_idle ? wdata             : wdata_reg;
    assign word_idx   = cur_addr[IDX_W+1:2];

    load_store_align u_align (
        .we          (cur_we),
        .funct3      (cur_funct3),
        .addr_lo     (cur_addr[1:0]),
        .wdata       (cur_wdata),
        .rword       (rword),
        .byte_en     (byte_en),
        .wdata_lanes (wdata_lanes),
        .bad         (bad),
        .rdata_ext   (rdata_ext)
    );

    assign commit     = !RST && ((in_idle && req && (LATENCY == 1)) ||
                                 (state_reg == BUSY && cnt_reg == CNT_W'(1)));
    assign mem_wr     = commit && cur_we && !bad;
    assign rdata_next = cur_we ? 32'h0 : rdata_ext;

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            logic [7:0] lane_mem [DEPTH_WORDS];
            always_ff @(posedge CLK) begin
                if (mem_wr && byte_en[gi]) begin
                    lane_mem[word_idx] <= wdata_lanes[8*gi +: 8];
                end
            end
            assign rword[8*gi +: 8] = lane_mem[word_idx];
        end
    endgenerate

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_reg  <= IDLE;
            cnt_reg    <= '0;
            we_reg     <= 1'b0;
            funct3_reg <= 3'b000;
            addr_reg   <= '0;
            wdata_reg  <= 32'h0;
            ready_reg  <= 1'b1;
            ack_reg    <= 1'b0;
            err_reg    <= 1'b0;
            rdata_reg  <= 32'h0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (req) begin
                        we_reg     <= we;
                        funct3_reg <= funct3;
                        addr_reg   <= addr[IDX_W+1:0];
                        wdata_reg  <= wdata;
                        ready_reg  <= 1'b0;
                        if (LATENCY > 1) begin
                            state_reg <= BUSY;
                            cnt_reg   <= CNT_W'(LATENCY - 1);
                        end else begin
                            state_reg <= RESP;
                            ack_reg   <= 1'b1;
                            err_reg   <= bad;
                            rdata_reg <= rdata_next;
                        end
                    end
                end
                BUSY: begin
                    if (cnt_reg == CNT_W'(1)) begin
                        state_reg <= RESP;
                        cnt_reg   <= '0;
                        ack_reg   <= 1'b1;
                        err_reg   <= bad;
                        rdata_reg <= rdata_next;
                    end else begin
                        cnt_reg <= cnt_reg - CNT_W'(1);
                    end
                end
                RESP: begin
                    state_reg <= IDLE;
                    ack_reg   <= 1'b0;
                    err_reg   <= 1'b0;
                    ready_reg <= 1'b1;
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign ready = ready_reg;
    assign ack   = ack_reg;
    assign err   = err_reg;
    assign rdata = rdata_reg;

endmodule
